// File: rtl/isa.v
// rtl/isa.v - shared ISA widths and ALU operation encodings
`ifndef ISA_V
`define ISA_V

`define XLEN 32

`define ALU_ADD 4'd0
`define ALU_SUB 4'd1
`define ALU_AND 4'd2
`define ALU_OR  4'd3
`define ALU_XOR 4'd4
`define ALU_SLL 4'd5
`define ALU_SRL 4'd6
`define ALU_SRA 4'd7
`define ALU_SLT 4'd8
`define ALU_SLTU 4'd9

`endif

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with load-use hazard bubble insertion
//
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   id_*                : decoded instruction entering EX (payload, indices, control)
//   ex_flush, ex_stall  : redirect kill and downstream hold from EX
//   ex_*                : registered copy of the id_* fields plus ex_valid
//   id_stall            : combinational hold request for IF/ID and PC
//   bubble_cnt, flush_cnt : saturating load-use bubble and flush event counters
`ifndef XLEN
`include "isa.v"
`endif

module id_ex_stage #(
  parameter int CNT_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [`XLEN-1:0]  id_pc,
  input  logic [`XLEN-1:0]  id_rs1_data,
  input  logic [`XLEN-1:0]  id_rs2_data,
  input  logic [`XLEN-1:0]  id_imm,
  input  logic [4:0]        id_rs1,
  input  logic [4:0]        id_rs2,
  input  logic [4:0]        id_rd,
  input  logic [2:0]        id_funct3,
  input  logic              id_uses_rs1,
  input  logic              id_uses_rs2,
  input  logic              id_branch,
  input  logic              id_MemRead,
  input  logic              id_MemToReg,
  input  logic              id_MemWrite,
  input  logic              id_ALUSrc,
  input  logic              id_RegWrite,
  input  logic              id_is_branch,
  input  logic              id_is_jump,
  input  logic              id_is_jal,
  input  logic              id_is_jalr,
  input  logic              id_is_load,
  input  logic              id_is_store,
  input  logic [3:0]        id_ALU_op,
  input  logic              ex_flush,
  input  logic              ex_stall,
  output logic              ex_valid,
  output logic [`XLEN-1:0]  ex_pc,
  output logic [`XLEN-1:0]  ex_rs1_data,
  output logic [`XLEN-1:0]  ex_rs2_data,
  output logic [`XLEN-1:0]  ex_imm,
  output logic [4:0]        ex_rs1,
  output logic [4:0]        ex_rs2,
  output logic [4:0]        ex_rd,
  output logic [2:0]        ex_funct3,
  output logic              ex_uses_rs1,
  output logic              ex_uses_rs2,
  output logic              ex_branch,
  output logic              ex_MemRead,
  output logic              ex_MemToReg,
  output logic              ex_MemWrite,
  output logic              ex_ALUSrc,
  output logic              ex_RegWrite,
  output logic              ex_is_branch,
  output logic              ex_is_jump,
  output logic              ex_is_jal,
  output logic              ex_is_jalr,
  output logic              ex_is_load,
  output logic              ex_is_store,
  output logic [3:0]        ex_ALU_op,
  output logic              id_stall,
  output logic [CNT_W-1:0]  bubble_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic load_use;
  logic bubble_ins;
  logic [11:0] id_ctrl;
  logic [11:0] ex_ctrl;

  // A load still in EX cannot forward to the instruction behind it; x0 is never a hazard.
  assign load_use = id_valid & ex_valid & ex_is_load & (ex_rd != 5'd0) &
                    ((id_uses_rs1 & (id_rs1 == ex_rd)) | (id_uses_rs2 & (id_rs2 == ex_rd)));

  assign id_stall   = ex_stall | (load_use & ~ex_flush);
  assign bubble_ins = load_use & ~ex_flush & ~ex_stall;

  assign id_ctrl = {id_branch, id_MemRead, id_MemToReg, id_MemWrite, id_ALUSrc, id_RegWrite,
                    id_is_branch, id_is_jump, id_is_jal, id_is_jalr, id_is_load, id_is_store};

  assign {ex_branch, ex_MemRead, ex_MemToReg, ex_MemWrite, ex_ALUSrc, ex_RegWrite,
          ex_is_branch, ex_is_jump, ex_is_jal, ex_is_jalr, ex_is_load, ex_is_store} = ex_ctrl;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || ex_flush || bubble_ins) begin
      // Bubble: nothing valid, no side effects, neutral ALU op.
      ex_valid    <= 1'b0;
      ex_pc       <= '0;
      ex_rs1_data <= '0;
      ex_rs2_data <= '0;
      ex_imm      <= '0;
      ex_rs1      <= '0;
      ex_rs2      <= '0;
      ex_rd       <= '0;
      ex_funct3   <= '0;
      ex_uses_rs1 <= 1'b0;
      ex_uses_rs2 <= 1'b0;
      ex_ctrl     <= '0;
      ex_ALU_op   <= `ALU_ADD;
    end else if (!ex_stall) begin
      ex_valid    <= id_valid;
      ex_pc       <= id_pc;
      ex_rs1_data <= id_rs1_data;
      ex_rs2_data <= id_rs2_data;
      ex_imm      <= id_imm;
      ex_rs1      <= id_rs1;
      ex_rs2      <= id_rs2;
      ex_rd       <= id_rd;
      ex_funct3   <= id_funct3;
      ex_uses_rs1 <= id_uses_rs1;
      ex_uses_rs2 <= id_uses_rs2;
      // An empty decode slot must not carry live control into EX.
      ex_ctrl     <= id_ctrl & {12{id_valid}};
      ex_ALU_op   <= id_ALU_op;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bubble_cnt <= '0;
      flush_cnt  <= '0;
    end else begin
      if (bubble_ins && bubble_cnt != '1) bubble_cnt <= bubble_cnt + CNT_ONE;
      if (ex_flush && flush_cnt != '1)    flush_cnt  <= flush_cnt + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - scoreboard bench for id_ex_stage against a reference model
`ifndef XLEN
`include "isa.v"
`endif

module tb_id_ex_stage;

  localparam int CNT_W = 4;
  localparam int CMAX  = 15;

  // Vector layout: [164] valid, [163:152] control, [151:120] pc, [119:88] rs1_data,
  // [87:56] rs2_data, [55:24] imm, [23:19] rs1, [18:14] rs2, [13:9] rd,
  // [8:6] funct3, [5] uses_rs1, [4] uses_rs2, [3:0] ALU_op.
  // Control order: branch MemRead MemToReg MemWrite ALUSrc RegWrite
  //                is_branch is_jump is_jal is_jalr is_load is_store
  typedef logic [164:0] vec_t;

  localparam vec_t MASK_ALL  = {165{1'b1}};
  localparam vec_t MASK_CTRL = {13'h1fff, 152'b0};

  typedef struct {
    vec_t v;
    vec_t m;
    int   bc;
    int   fc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ex_flush = 1'b0;
  logic ex_stall = 1'b0;
  vec_t id_vec = '0;

  logic id_valid, id_uses_rs1, id_uses_rs2;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic [2:0] id_funct3;
  logic [11:0] id_ctrl;
  logic [3:0] id_ALU_op;

  logic ex_valid, ex_uses_rs1, ex_uses_rs2;
  logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0] ex_rs1, ex_rs2, ex_rd;
  logic [2:0] ex_funct3;
  logic ex_branch, ex_MemRead, ex_MemToReg, ex_MemWrite, ex_ALUSrc, ex_RegWrite;
  logic ex_is_branch, ex_is_jump, ex_is_jal, ex_is_jalr, ex_is_load, ex_is_store;
  logic [3:0] ex_ALU_op;
  logic id_stall;
  logic [CNT_W-1:0] bubble_cnt, flush_cnt;
  vec_t ex_vec;

  assign {id_valid, id_ctrl, id_pc, id_rs1_data, id_rs2_data, id_imm, id_rs1, id_rs2, id_rd,
          id_funct3, id_uses_rs1, id_uses_rs2, id_ALU_op} = id_vec;

  assign ex_vec = {ex_valid, ex_branch, ex_MemRead, ex_MemToReg, ex_MemWrite, ex_ALUSrc,
                   ex_RegWrite, ex_is_branch, ex_is_jump, ex_is_jal, ex_is_jalr, ex_is_load,
                   ex_is_store, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1, ex_rs2, ex_rd,
                   ex_funct3, ex_uses_rs1, ex_uses_rs2, ex_ALU_op};

  id_ex_stage #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_funct3(id_funct3),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .id_branch(id_ctrl[11]), .id_MemRead(id_ctrl[10]), .id_MemToReg(id_ctrl[9]),
    .id_MemWrite(id_ctrl[8]), .id_ALUSrc(id_ctrl[7]), .id_RegWrite(id_ctrl[6]),
    .id_is_branch(id_ctrl[5]), .id_is_jump(id_ctrl[4]), .id_is_jal(id_ctrl[3]),
    .id_is_jalr(id_ctrl[2]), .id_is_load(id_ctrl[1]), .id_is_store(id_ctrl[0]),
    .id_ALU_op(id_ALU_op), .ex_flush(ex_flush), .ex_stall(ex_stall),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
    .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_funct3(ex_funct3),
    .ex_uses_rs1(ex_uses_rs1), .ex_uses_rs2(ex_uses_rs2),
    .ex_branch(ex_branch), .ex_MemRead(ex_MemRead), .ex_MemToReg(ex_MemToReg),
    .ex_MemWrite(ex_MemWrite), .ex_ALUSrc(ex_ALUSrc), .ex_RegWrite(ex_RegWrite),
    .ex_is_branch(ex_is_branch), .ex_is_jump(ex_is_jump), .ex_is_jal(ex_is_jal),
    .ex_is_jalr(ex_is_jalr), .ex_is_load(ex_is_load), .ex_is_store(ex_is_store),
    .ex_ALU_op(ex_ALU_op), .id_stall(id_stall),
    .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  function automatic void chk(input string name, input vec_t act, input vec_t exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endfunction

  // Reference model state
  vec_t m_ex;
  vec_t m_mask;
  int   m_bc, m_fc;
  exp_t ex_q[$];
  bit   stall_q[$];

  function automatic vec_t bubble();
    vec_t b;
    b = '0;
    b[3:0] = `ALU_ADD;
    return b;
  endfunction

  task automatic step(input vec_t v, input bit st, input bit fl, input bit rn);
    bit lu;
    exp_t e;
    @(posedge clk);
    #2;
    id_vec = v;
    ex_stall = st;
    ex_flush = fl;
    if (rst_n && !rn) begin
      rst_n = 1'b0;
      #1;
      chk("async_rst_ex_valid", vec_t'(ex_valid), vec_t'(0));
      chk("async_rst_bubble_cnt", vec_t'(bubble_cnt), vec_t'(0));
      chk("async_rst_flush_cnt", vec_t'(flush_cnt), vec_t'(0));
    end else begin
      rst_n = rn;
    end
    if (!rn) begin
      m_ex = bubble(); m_mask = MASK_ALL; m_bc = 0; m_fc = 0;
    end
    // Hazard from the spec's rule: a live load in EX writing a register this slot reads.
    lu = rn && v[164] && m_ex[164] && m_ex[153] && (m_ex[13:9] != 0) &&
         ((v[5] && v[23:19] == m_ex[13:9]) || (v[4] && v[18:14] == m_ex[13:9]));
    stall_q.push_back(st || (lu && !fl));
    if (rn) begin
      if (fl) begin
        m_ex = bubble(); m_mask = MASK_ALL;
        if (m_fc < CMAX) m_fc++;
      end else if (st) begin
        // hold
      end else if (lu) begin
        m_ex = bubble(); m_mask = MASK_ALL;
        if (m_bc < CMAX) m_bc++;
      end else begin
        m_ex = v;
        m_mask = MASK_ALL;
        if (!v[164]) begin
          m_ex[163:152] = '0;
          m_mask = MASK_CTRL;
        end
      end
    end
    e.v = m_ex; e.m = m_mask; e.bc = m_bc; e.fc = m_fc;
    ex_q.push_back(e);
  endtask

  function automatic vec_t rand_instr(input bit load_bias);
    vec_t v;
    v = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    v[164] = ($urandom_range(0, 7) != 0);
    v[23:19] = 5'($urandom_range(0, 3));
    v[18:14] = 5'($urandom_range(0, 3));
    v[13:9]  = 5'($urandom_range(0, 3));
    if (load_bias) v[153] = ($urandom_range(0, 9) < 4);
    return v;
  endfunction

  function automatic vec_t mk(input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic [4:0] rd, input bit u1, input bit u2, input bit ld);
    vec_t v;
    v = '0;
    v[164] = 1'b1;
    v[158] = 1'b1;           // RegWrite
    v[153] = ld;             // is_load
    v[151:120] = pc;
    v[23:19] = rs1; v[18:14] = rs2; v[13:9] = rd;
    v[5] = u1; v[4] = u2;
    return v;
  endfunction

  // Monitor: id_stall mid-cycle
  initial begin
    bit es;
    forever begin
      @(negedge clk);
      if (stall_q.size() != 0) begin
        es = stall_q.pop_front();
        chk("id_stall", vec_t'(id_stall), vec_t'(es));
      end
    end
  end

  // Monitor: EX register and counters just after each edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (ex_q.size() != 0) begin
        e = ex_q.pop_front();
        chk("ex_regs", ex_vec & e.m, e.v & e.m);
        chk("bubble_cnt", vec_t'(bubble_cnt), vec_t'(e.bc));
        chk("flush_cnt", vec_t'(flush_cnt), vec_t'(e.fc));
      end
    end
  end

  initial begin
    vec_t a;
    m_ex = bubble(); m_mask = MASK_ALL; m_bc = 0; m_fc = 0;
    #1;
    chk("reset_ex_valid", vec_t'(ex_valid), vec_t'(0));
    chk("reset_ex_vec", ex_vec, bubble());
    chk("reset_id_stall", vec_t'(id_stall), vec_t'(0));
    step('0, 1'b0, 1'b0, 1'b0);
    step('0, 1'b0, 1'b0, 1'b1);
    // plain flow: add x3,x1,x2 at 0x100
    step(mk(32'h100, 5'd1, 5'd2, 5'd3, 1, 1, 0), 0, 0, 1);
    // load-use: lw x5 then dependent on rs1=x5
    step(mk(32'h104, 5'd1, 5'd0, 5'd5, 1, 0, 1), 0, 0, 1);
    a = mk(32'h108, 5'd5, 5'd2, 5'd6, 1, 1, 0);
    step(a, 0, 0, 1);
    step(a, 0, 0, 1);
    // no hazard: lw x0, then rs1=0; lw x7 then rs2 match with uses_rs2=0
    step(mk(32'h10c, 5'd1, 5'd0, 5'd0, 1, 0, 1), 0, 0, 1);
    step(mk(32'h110, 5'd0, 5'd0, 5'd8, 1, 0, 0), 0, 0, 1);
    step(mk(32'h114, 5'd1, 5'd0, 5'd7, 1, 0, 1), 0, 0, 1);
    step(mk(32'h118, 5'd2, 5'd7, 5'd8, 1, 0, 0), 0, 0, 1);
    // simultaneous flush + stall + load-use
    step(mk(32'h11c, 5'd1, 5'd0, 5'd9, 1, 0, 1), 0, 0, 1);
    step(mk(32'h120, 5'd9, 5'd0, 5'd1, 1, 0, 0), 1, 1, 1);
    // hold for 3 cycles with varying inputs, then release
    step(mk(32'h124, 5'd1, 5'd2, 5'd3, 1, 1, 0), 0, 0, 1);
    for (int i = 0; i < 3; i++) step(rand_instr(0), 1, 0, 1);
    step(mk(32'h128, 5'd2, 5'd3, 5'd4, 1, 1, 0), 0, 0, 1);
    // randomized traffic
    for (int i = 0; i < 300; i++)
      step(rand_instr(1), ($urandom_range(0, 9) == 0), ($urandom_range(0, 11) == 0), 1);
    // reset mid-stall, then resume
    step(mk(32'h200, 5'd1, 5'd2, 5'd3, 1, 1, 0), 0, 0, 1);
    step(rand_instr(0), 1, 0, 0);
    step(rand_instr(0), 1, 0, 0);
    step(mk(32'h204, 5'd1, 5'd2, 5'd3, 1, 1, 0), 0, 0, 1);
    // saturation: 20 load-use bubbles
    for (int i = 0; i < 20; i++) begin
      step(mk(32'h300, 5'd1, 5'd0, 5'd10, 1, 0, 1), 0, 0, 1);
      a = mk(32'h304, 5'd10, 5'd0, 5'd11, 1, 0, 0);
      step(a, 0, 0, 1);
      step(a, 0, 0, 1);
    end
    step('0, 0, 0, 1);
    repeat (3) @(posedge clk);
    #2;
    chk("bubble_cnt_saturated", vec_t'(bubble_cnt), vec_t'(CMAX));
    chk("scoreboard_drained", vec_t'(ex_q.size() + stall_q.size()), vec_t'(0));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have parameter CNT_W, default 32, width of the bubble/flush performance counters.
REQ-002 SHALL take data width from `XLEN in rtl/isa.v; no local width parameter.
REQ-003 SHALL have port clk, input, 1, sole clock; all state on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port id_valid, input, 1, decode slot holds a real instruction.
REQ-006 SHALL have ports id_pc, id_rs1_data, id_rs2_data, id_imm, input, `XLEN each, decode payload.
REQ-007 SHALL have ports id_rs1, id_rs2, id_rd, input, 5 each, register indices.
REQ-008 SHALL have port id_funct3, input, 3, passed to EX/MEM for branch type and access size.
REQ-009 SHALL have ports id_uses_rs1, id_uses_rs2, input, 1 each, instruction reads that source.
REQ-010 SHALL have ports id_branch, id_MemRead, id_MemToReg, id_MemWrite, id_ALUSrc, id_RegWrite, id_is_branch, id_is_jump, id_is_jal, id_is_jalr, id_is_load, id_is_store, input, 1 each, decoded control.
REQ-011 SHALL have port id_ALU_op, input, 4, decoded ALU operation.
REQ-012 SHALL have port ex_flush, input, 1, redirect resolved in EX; kill the instruction entering EX.
REQ-013 SHALL have port ex_stall, input, 1, downstream back-pressure; hold EX.
REQ-014 SHALL have output ex_valid plus an ex_-prefixed registered copy of every input in REQ-006..REQ-011, same widths.
REQ-015 SHALL have port id_stall, output, 1, combinational; upstream IF/ID and PC hold when high.
REQ-016 SHALL have ports bubble_cnt, flush_cnt, output, CNT_W each, saturating event counters.

Function
REQ-017 SHALL detect load-use: load_use = id_valid & ex_valid & ex_is_load & (ex_rd != 0) & ((id_uses_rs1 & id_rs1 == ex_rd) | (id_uses_rs2 & id_rs2 == ex_rd)).
REQ-018 SHALL drive id_stall = ex_stall | (load_use & ~ex_flush).
REQ-019 SHALL update EX register each edge with priority: ex_flush > ex_stall > load_use > normal.
REQ-020 SHALL, on ex_flush, load a bubble regardless of ex_stall or load_use.
REQ-021 SHALL, on ex_stall without flush, hold all ex_ outputs unchanged.
REQ-022 SHALL, on load_use without flush/stall, load a bubble; exactly one bubble per load-use pair (next cycle EX holds a bubble, so load_use deasserts).
REQ-023 SHALL, on normal advance, capture all id_ fields with ex_valid = id_valid.
REQ-024 SHALL define bubble as ex_valid = 0, all 1-bit ex_ control = 0, ex_ALU_op = `ALU_ADD, all data/index fields = 0.
REQ-025 SHALL force ex_ control to 0 whenever id_valid = 0 is captured (no side effects from invalid slots).
REQ-026 SHALL add latency of exactly one cycle from ID to EX when no stall, flush or hazard.
REQ-027 SHALL increment bubble_cnt once per cycle in which a load-use bubble is inserted; flush_cnt once per cycle in which ex_flush is high; both saturate at all-ones, never wrap.

Reset
REQ-028 SHALL, while rst_n = 0, asynchronously force EX register to the bubble of REQ-024 and both counters to 0.
REQ-029 SHALL, with rst_n = 0, drive id_stall = ex_stall only (ex_valid = 0 blocks load_use).
REQ-030 SHALL resume normal capture on the first rising edge after rst_n deasserts; reset mid-stall discards held instruction.

Verification
REQ-031 Plain flow: id add x3,x1,x2 valid, pc=0x100 -> next cycle ex_valid=1, ex_pc=0x100, ex_rd=3, ex_RegWrite=1, id_stall=0.
REQ-032 Load-use: lw x5 in EX, id uses rs1=5 -> id_stall=1 one cycle, bubble in EX, then dependent enters EX; bubble_cnt=1.
REQ-033 No hazard: lw x0 in EX with id rs1=0, or id_uses_rs2=0 with rs2 match -> id_stall=0, no bubble.
REQ-034 Simultaneous: ex_flush=1 with load_use=1 and ex_stall=1 -> id_stall=1 (from ex_stall), EX = bubble, flush_cnt+1, bubble_cnt unchanged.
REQ-035 Hold: ex_stall=1 for 3 cycles with varying id_ -> ex_ outputs constant; release -> current id_ captured.
REQ-036 Async reset mid-operation: rst_n low between edges -> ex_valid=0, counters=0 immediately; saturation check with CNT_W=4: 20 load-use bubbles -> bubble_cnt=15.
